ps2_xmtr: RTL

Host-to-device PS/2 transmitter. It sends command bytes (LED control, typematic rate, reset, etc.) to the keyboard, and sits beside the receive-side keyboard controller on the same two-register bus slot style. It drives the open-drain PS/2 clock and data lines through active-high pull-low enables, follows the device-generated clock, and frames start/8 data/odd parity/stop. It then checks the device acknowledge bit and reports idle/error status with an optional interrupt.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_sync.sv | 33 +++
 rtl/ps2_xmtr.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 states, register map and frame helpers
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        ACK,
        WAITIDLE
    } ps2_state_t;

    localparam logic ADDR_CTRL = 1'b0;
    localparam logic ADDR_DATA = 1'b1;

    localparam int RDY = 0;
    localparam int IEN = 1;
    localparam int ERR = 2;

    localparam int FRAME_BITS = 10;

    // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
    function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// rtl/ps2_sync.sv - two-flop PS/2 pin synchronizer with clock falling-edge detect
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s,
    output logic clk_fe
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Idle PS/2 lines float high, so the flops reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk};
            data_ff  <= {data_ff[0], ps2_data};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_s  = clk_ff[1];
    assign data_s = data_ff[1];
    assign clk_fe = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_xmtr.sv
// rtl/ps2_xmtr.sv - PS/2 host-to-device transmitter; PS2_XMTR_TIMEOUT_EN adds a frame timeout
module ps2_xmtr
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stb,
    input  logic       we,
    input  logic       addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ack,
    output logic       irq,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ps2_xmtr: cycle parameters must be at least 1");
    end

    ps2_state_t            state, state_nx;
    logic [INH_W-1:0]      inh_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic [3:0]            bitcnt;
    logic                  data_bit;
    logic                  err, ien;
    logic [7:0]            tx_byte;
    logic [7:0]            status;
    logic                  clk_s, data_s, clk_fe;
    logic                  rdy, wr_ctrl, wr_data, start, timeout;

    ps2_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .clk_s   (clk_s),
        .data_s  (data_s),
        .clk_fe  (clk_fe)
    );

    assign rdy     = (state == IDLE);
    assign wr_ctrl = stb & we & (addr == ADDR_CTRL);
    assign wr_data = stb & we & (addr == ADDR_DATA);
    assign start   = wr_data & rdy;

`ifdef PS2_XMTR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            in_frame;

    // Covers everything after clock release; inhibit time is host-controlled.
    assign in_frame = (state == XFER) || (state == ACK) || (state == WAITIDLE);
    assign timeout  = in_frame && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !in_frame) to_cnt <= '0;
        else                  to_cnt <= to_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = INHIBIT;
            INHIBIT:  if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) state_nx = REQ;
            REQ:      state_nx = XFER;
            XFER:     if (clk_fe && bitcnt == 4'(FRAME_BITS - 1)) state_nx = ACK;
            ACK:      if (clk_fe) state_nx = WAITIDLE;
            WAITIDLE: if (clk_s && data_s) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (timeout) state_nx = IDLE;
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state)
            INHIBIT: ps2_clk_oe = 1'b1;
            REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            XFER:    ps2_data_oe = data_bit;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inh_cnt  <= '0;
            shift    <= '0;
            bitcnt   <= '0;
            data_bit <= 1'b0;
            err      <= 1'b0;
            ien      <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            if (wr_ctrl) ien <= data_in[IEN];
            if (start) begin
                tx_byte <= data_in;
                err     <= 1'b0;
                shift   <= ps2_frame(data_in);
                inh_cnt <= '0;
            end
            if (state == INHIBIT) inh_cnt <= inh_cnt + 1'b1;
            // Start bit stays on the line until the device's first falling edge.
            if (state == REQ) begin
                bitcnt   <= '0;
                data_bit <= 1'b1;
            end
            if (state == XFER && clk_fe) begin
                data_bit <= ~shift[0];
                shift    <= {1'b0, shift[FRAME_BITS-1:1]};
                bitcnt   <= bitcnt + 1'b1;
            end
            if (state == ACK && clk_fe && data_s) err <= 1'b1;
            if (timeout) err <= 1'b1;
        end
    end

    always_comb begin
        status      = 8'h00;
        status[RDY] = rdy;
        status[IEN] = ien;
        status[ERR] = err;
    end

    assign data_out = (addr == ADDR_DATA) ? tx_byte : status;
    assign ack      = stb;
    assign irq      = ien & rdy;

endmodule
